calc_ctrl: RTL and testbench

Operation sequencer for the calculator datapath. Takes raw active-low switches and push-buttons, then synchronises and debounces them. Steps the user through operand A entry, operand B entry and operator entry, then issues a single-cycle start to the ALU and waits for its completion. It holds the result or error for display until the next entry or clear.

---
 rtl/calc_ctrl.sv | 174 +++++++++++++++++
 tb/tb_calc_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_ctrl.sv
// Calculator operation sequencer: conditions switches/keys, walks A -> B -> op entry, starts the ALU and holds result/error.
// Key events arrive 2 + DEB_CYCLES + 1 cycles after a raw press; no backpressure, enters outside entry states are dropped.
module calc_ctrl #(
    parameter int DEB_CYCLES = 50000,
    parameter int TO_CYCLES  = 255
) (
    input  logic       clk_ctrl,
    input  logic       rst_n,
    input  logic [3:0] sw_n,
    input  logic [1:0] key_n,
    input  logic       alu_done,
    input  logic [7:0] alu_result,
    input  logic       alu_err,
    output logic [3:0] operand_a,
    output logic [3:0] operand_b,
    output logic [1:0] alu_op,
    output logic       alu_start,
    output logic [7:0] disp,
    output logic       err,
    output logic [2:0] state_led
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(TO_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TO_CYCLES - 1);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_WAIT = 3'd4,
        S_SHOW = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [3:0]    sw_meta;
    logic [3:0]    sw_sync;
    logic [1:0]    key_meta;
    logic [1:0]    key_sync;
    logic [1:0]    key_acc;
    logic [1:0]    key_ev;
    logic [3:0]    sw_val;
    logic [7:0]    result_q;
    logic [TW-1:0] to_cnt;
    logic          enter_ev;
    logic          clear_ev;

    always_ff @(posedge clk_ctrl or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta  <= 4'hF;
            sw_sync  <= 4'hF;
            key_meta <= 2'b11;
            key_sync <= 2'b11;
        end else begin
            sw_meta  <= sw_n;
            sw_sync  <= sw_meta;
            key_meta <= key_n;
            key_sync <= key_meta;
        end
    end

    assign sw_val = ~sw_sync;

    // Accepted level only moves after DEB_CYCLES consecutive cycles of disagreement.
    for (genvar k = 0; k < 2; k++) begin : g_deb
        logic [DW-1:0] deb_cnt;

        always_ff @(posedge clk_ctrl or negedge rst_n) begin
            if (!rst_n) begin
                deb_cnt    <= '0;
                key_acc[k] <= 1'b1;
                key_ev[k]  <= 1'b0;
            end else begin
                key_ev[k] <= 1'b0;
                if (key_sync[k] != key_acc[k]) begin
                    if (deb_cnt == DEB_LAST) begin
                        deb_cnt    <= '0;
                        key_acc[k] <= key_sync[k];
                        key_ev[k]  <= ~key_sync[k];
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end else begin
                    deb_cnt <= '0;
                end
            end
        end
    end

    assign enter_ev = key_ev[0];
    assign clear_ev = key_ev[1];

    always_ff @(posedge clk_ctrl or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_A:    if (enter_ev) state_d = S_B;
            S_B:    if (enter_ev) state_d = S_OP;
            S_OP:   if (enter_ev) state_d = S_EXEC;
            S_EXEC: state_d = S_WAIT;
            S_WAIT: begin
                if (alu_done) begin
                    state_d = alu_err ? S_ERR : S_SHOW;
                end else if (to_cnt == TO_LAST) begin
                    state_d = S_ERR;
                end
            end
            S_SHOW: if (enter_ev) state_d = S_A;
            S_ERR:  if (enter_ev) state_d = S_A;
            default: state_d = S_A;
        endcase
        // Clear outranks any simultaneous enter.
        if (clear_ev) begin
            state_d = S_A;
        end
    end

    always_ff @(posedge clk_ctrl or negedge rst_n) begin
        if (!rst_n) begin
            operand_a <= '0;
            operand_b <= '0;
            alu_op    <= '0;
            result_q  <= '0;
            to_cnt    <= '0;
        end else if (clear_ev) begin
            operand_a <= '0;
            operand_b <= '0;
            alu_op    <= '0;
            result_q  <= '0;
            to_cnt    <= '0;
        end else begin
            case (state_q)
                S_A:    if (enter_ev) operand_a <= sw_val;
                S_B:    if (enter_ev) operand_b <= sw_val;
                S_OP:   if (enter_ev) alu_op <= sw_val[1:0];
                S_EXEC: to_cnt <= '0;
                S_WAIT: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (alu_done && !alu_err) begin
                        result_q <= alu_result;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        disp = 8'h00;
        case (state_q)
            S_A, S_B: disp = {4'h0, sw_val};
            S_OP:     disp = {6'h0, sw_val[1:0]};
            S_SHOW:   disp = result_q;
            S_ERR:    disp = 8'hEE;
            default:  disp = 8'h00;
        endcase
    end

    assign alu_start = (state_q == S_EXEC);
    assign err       = (state_q == S_ERR);
    assign state_led = state_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// Randomized scoreboard bench for calc_ctrl: model pushes expected state snapshots, monitor pops on every observed change.
module tb_calc_ctrl;

    localparam int DEB = 4;
    localparam int TO  = 8;

    logic       clk_ctrl = 1'b0;
    logic       rst_n    = 1'b0;
    logic [3:0] sw_n     = 4'hF;
    logic [1:0] key_n    = 2'b11;
    logic       alu_done = 1'b0;
    logic [7:0] alu_result = 8'h00;
    logic       alu_err  = 1'b0;
    logic [3:0] operand_a;
    logic [3:0] operand_b;
    logic [1:0] alu_op;
    logic       alu_start;
    logic [7:0] disp;
    logic       err;
    logic [2:0] state_led;

    calc_ctrl #(.DEB_CYCLES(DEB), .TO_CYCLES(TO)) dut (
        .clk_ctrl  (clk_ctrl),
        .rst_n     (rst_n),
        .sw_n      (sw_n),
        .key_n     (key_n),
        .alu_done  (alu_done),
        .alu_result(alu_result),
        .alu_err   (alu_err),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .alu_op    (alu_op),
        .alu_start (alu_start),
        .disp      (disp),
        .err       (err),
        .state_led (state_led)
    );

    always #5 clk_ctrl = ~clk_ctrl;

    typedef struct {
        logic [13:0] tup;
        bit          dchk;
        logic [7:0]  d;
    } snap_t;

    snap_t       expq[$];
    logic [13:0] last_tup = 14'h0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int starts = 0;
    int exp_starts = 0;
    int cyc_wait = -1;
    int cyc_err = -1;

    // Reference model: abstract calculator state, not the RTL's registers.
    int         m_st = 0;
    logic [3:0] m_a = 0, m_b = 0;
    logic [1:0] m_op = 0;
    logic [7:0] m_res = 0;
    logic [3:0] cur_sw = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_model(input bit disp_valid);
        snap_t s;
        s.tup  = {3'(m_st), m_a, m_b, m_op, (m_st == 6)};
        s.dchk = disp_valid;
        case (m_st)
            0, 1:    s.d = {4'h0, cur_sw};
            2:       s.d = {6'h0, cur_sw[1:0]};
            5:       s.d = m_res;
            6:       s.d = 8'hEE;
            default: begin s.d = 8'h00; s.dchk = 1'b0; end
        endcase
        if (s.tup != last_tup) begin
            expq.push_back(s);
            last_tup = s.tup;
        end
    endtask

    task automatic ev_enter();
        case (m_st)
            0: begin m_a = cur_sw; m_st = 1; end
            1: begin m_b = cur_sw; m_st = 2; end
            5, 6: m_st = 0;
            default: ;
        endcase
        push_model(1'b1);
    endtask

    task automatic ev_clear();
        m_st = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0;
        push_model(1'b1);
    endtask

    task automatic set_sw(input logic [3:0] v);
        cur_sw = v;
        sw_n   = ~v;
        repeat (4) @(negedge clk_ctrl);
    endtask

    task automatic press(input logic [1:0] keys, input int hold);
        key_n = ~keys;
        repeat (hold) @(negedge clk_ctrl);
        key_n = 2'b11;
        repeat (DEB + 6) @(negedge clk_ctrl);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk_ctrl);
            if (state_led == s) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_state actual=%0d required=%0d", state_led, s);
        end
    endtask

    // mode 0: ALU ok, 1: ALU error, 2: timeout, 3: reset while waiting
    task automatic run_op(input int mode, input int delay, input logic [7:0] r);
        m_op = cur_sw[1:0];
        m_st = 3;
        push_model(1'b1);
        exp_starts++;
        m_st = 4;
        push_model(1'b1);
        cyc_err = -1;
        key_n[0] = 1'b0;
        wait_state(3'd4, 40);
        repeat (delay) @(negedge clk_ctrl);
        case (mode)
            0, 1: begin
                if (mode == 0) begin m_res = r; m_st = 5; end
                else m_st = 6;
                push_model(1'b1);
                alu_done = 1'b1; alu_err = (mode == 1); alu_result = r;
                @(negedge clk_ctrl);
                alu_done = 1'b0; alu_err = 1'b0;
            end
            2: begin
                m_st = 6;
                push_model(1'b1);
                repeat (TO + 4) @(negedge clk_ctrl);
                chk("timeout_latency", 32'(cyc_err - cyc_wait), TO);
            end
            default: begin
                m_st = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0;
                push_model(1'b0);
                key_n = 2'b11;
                rst_n = 1'b0;
                repeat (2) @(negedge clk_ctrl);
                rst_n = 1'b1;
                repeat (2) @(negedge clk_ctrl);
                alu_done = 1'b1; alu_result = 8'hA5;
                @(negedge clk_ctrl);
                alu_done = 1'b0;
                repeat (4) @(negedge clk_ctrl);
                chk("late_done_state", state_led, 0);
            end
        endcase
        key_n = 2'b11;
        repeat (DEB + 6) @(negedge clk_ctrl);
    endtask

    initial begin : monitor
        logic [13:0] prev = 14'h0;
        logic [13:0] cur;
        snap_t       s;
        forever begin
            @(negedge clk_ctrl);
            cyc++;
            if (alu_start === 1'b1) starts++;
            cur = {state_led, operand_a, operand_b, alu_op, err};
            if (cur !== prev) begin
                prev = cur;
                if (state_led == 3'd4) cyc_wait = cyc;
                if (state_led == 3'd6) cyc_err = cyc;
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change actual=%h required=none", cur);
                end else begin
                    s = expq.pop_front();
                    if (cur !== s.tup) begin
                        errors++;
                        $display("FAIL snapshot actual=%h required=%h", cur, s.tup);
                    end
                    if (s.dchk) chk("disp", disp, s.d);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        repeat (3) @(negedge clk_ctrl);
        chk("rst_state", state_led, 0);
        chk("rst_a", operand_a, 0);
        chk("rst_b", operand_b, 0);
        chk("rst_op", alu_op, 0);
        chk("rst_start", alu_start, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_ctrl);
        chk("rst_disp", disp, 0);

        // Full sequence with a debounce glitch first
        set_sw(4'h5);
        key_n[0] = 1'b0;
        repeat (3) @(negedge clk_ctrl);
        key_n[0] = 1'b1;
        repeat (12) @(negedge clk_ctrl);
        chk("glitch_state", state_led, 0);
        ev_enter(); press(2'b01, 10);
        set_sw(4'h3); ev_enter(); press(2'b01, 10);
        set_sw(4'h1); run_op(0, 0, 8'h08);
        chk("seq_a", operand_a, 4'h5);
        chk("seq_b", operand_b, 4'h3);
        chk("seq_op", alu_op, 2'h1);
        chk("seq_disp", disp, 8'h08);
        chk("seq_state", state_led, 5);
        ev_enter(); press(2'b01, 10);

        // ALU error path
        set_sw(4'h9); ev_enter(); press(2'b01, 10);
        set_sw(4'h2); ev_enter(); press(2'b01, 10);
        set_sw(4'h3); run_op(1, 2, 8'h00);
        chk("aerr_err", err, 1);
        chk("aerr_disp", disp, 8'hEE);
        chk("aerr_state", state_led, 6);
        ev_enter(); press(2'b01, 10);
        chk("aerr_exit_err", err, 0);
        chk("aerr_exit_state", state_led, 0);

        // Timeout path
        set_sw(4'hC); ev_enter(); press(2'b01, 10);
        set_sw(4'h6); ev_enter(); press(2'b01, 10);
        set_sw(4'h2); run_op(2, 0, 8'h00);
        ev_enter(); press(2'b01, 10);

        // Clear beats enter in S_B
        set_sw(4'h7); ev_enter(); press(2'b01, 10);
        set_sw(4'h4); ev_clear(); press(2'b11, 10);
        chk("clr_state", state_led, 0);
        chk("clr_a", operand_a, 0);
        chk("clr_b", operand_b, 0);

        for (int it = 0; it < 8; it++) begin
            set_sw(4'($urandom_range(0, 15))); ev_enter(); press(2'b01, 10);
            set_sw(4'($urandom_range(0, 15))); ev_enter(); press(2'b01, 10);
            set_sw(4'($urandom_range(0, 15)));
            run_op($urandom_range(0, 2), $urandom_range(0, 5), 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                ev_clear(); press(2'b10, 10);
            end else begin
                ev_enter(); press(2'b01, 10);
            end
        end

        // Reset while waiting for the ALU, then a stray done
        set_sw(4'hB); ev_enter(); press(2'b01, 10);
        set_sw(4'hD); ev_enter(); press(2'b01, 10);
        set_sw(4'h1); run_op(3, 1, 8'h00);
        chk("post_rst_a", operand_a, 0);

        repeat (10) @(negedge clk_ctrl);
        chk("queue_empty", expq.size(), 0);
        chk("start_pulses", starts, exp_starts);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
